pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It sits beside the IF/ID and ID/EX pipeline registers and computes their write-enable, flush, bubble and hold controls, plus the PC write enable. It resolves three conditions: load-use hazards, control redirects resolved in EX, and multi-cycle data-memory waits. A watchdog halts the pipeline if memory never responds.

## Interface
Parameters:
- MAX_WAIT, 15: memory-wait cycles allowed before timeout (1..255).
- PERF_W, 16: width of the performance counters (used only with HAZARD_PERF_EN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ifidRs  in  5  rs field of the instruction in ID.
- ifidRt  in  5  rt field of the instruction in ID.
- ifidUsesRt  in  1  ID instruction reads rt (R-type, sw, beq).
- idexMemRead  in  1  instruction in EX is a load.
- idexRt  in  5  load destination register in EX.
- exPcSrc  in  2  PC source resolved in EX; nonzero means redirect.
- memReq  in  1  instruction in MEM accesses data memory.
- memReady  in  1  data memory completes the access this cycle.
- pcWrite  out  1  PC register update enable.
- ifidWrite  out  1  IF/ID update enable.
- ifidFlush  out  1  IF/ID loads a NOP.
- idexBubble  out  1  ID/EX loads zeroed control (RegWrite=0, MemWrite=0, MemRead=0, PcSrc=0).
- pipeHold  out  1  ID/EX, EX/MEM and MEM/WB keep their contents.
- halted  out  1  pipeline frozen after a memory timeout.
- state  out  2  FSM state for debug: 00 RUN, 01 MEM_WAIT, 10 HALT.
- stallCycles  out  PERF_W  only with HAZARD_PERF_EN.
- flushCount  out  PERF_W  only with HAZARD_PERF_EN.

## Operation
- Outputs are combinational from the registered state and the current inputs (Mealy). The default is normal advance: pcWrite=1, ifidWrite=1, all other controls 0.
- loadUse = idexMemRead && idexRt!=0 && (idexRt==ifidRs || (ifidUsesRt && idexRt==ifidRt)).
- memStall = memReq && !memReady.

RUN state, first match wins:
- memStall: pcWrite=0, ifidWrite=0, pipeHold=1. Next state is MEM_WAIT and waitCnt=1.
- exPcSrc!=0: pcWrite=1, ifidWrite=1, ifidFlush=1, idexBubble=1. The fetched and decoded wrong-path instructions are squashed. Stay in RUN.
- loadUse: pcWrite=0, ifidWrite=0, idexBubble=1. Exactly one bubble per load-use pair. Stay in RUN.
- Otherwise: normal advance.

MEM_WAIT state:
- memReady=1: normal advance this cycle, and any pending redirect or loadUse is evaluated with RUN rules in this same cycle. Next state is RUN and waitCnt is cleared.
- memReady=0 and waitCnt<MAX_WAIT: full freeze (as in the RUN memStall case). waitCnt increments.
- memReady=0 and waitCnt==MAX_WAIT: full freeze and next state is HALT.

HALT state:
- pcWrite=0, ifidWrite=0, pipeHold=1, halted=1.
- Only rst exits this state. memReady is ignored.

General rules:
- waitCnt is 8 bits and internal; it is never compared beyond MAX_WAIT.
- The EX inputs are held stable during a freeze because ID/EX holds, so a redirect or load-use arriving during MEM_WAIT is never lost.

## Timing
- Reset values: state=RUN, waitCnt=0, halted=0, counters=0.
- Output values during reset follow RUN with the current inputs.
- A reset asserted mid-wait or in HALT returns to RUN asynchronously.
- Load-use costs exactly 1 stall cycle; the load reaches MEM on the next edge.
- A redirect costs 2 squashed slots (IF/ID and ID/EX) and no stall cycle.
- A memory wait of N cycles with memReady low costs N frozen cycles; the release is in the cycle memReady rises.
- Timeout: HALT is entered at the edge ending frozen cycle MAX_WAIT+1 with memReady still low.
- Redirect and loadUse in the same cycle: the redirect wins, the bubble is applied, and the PC advances to the target.

## Configuration
- HAZARD_PERF_EN defined:
  - stallCycles counts every cycle with pcWrite=0 in RUN or MEM_WAIT.
  - flushCount counts every cycle with ifidFlush=1.
  - Both counters saturate at all-ones, reset to 0, and do not count in HALT.
- HAZARD_PERF_EN undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Load-use: lw $2 in EX (idexMemRead=1, idexRt=2) with ifidRs=2 → one cycle of pcWrite=0, ifidWrite=0, idexBubble=1, then normal advance. Repeat with idexRt=0 → no stall.
- Redirect: exPcSrc=01 with loadUse also true → ifidFlush=1, idexBubble=1, pcWrite=1 that cycle; flushCount increments by 1.
- Memory wait: memReq=1, memReady=0 for 3 cycles, then 1 → state sequence RUN, MEM_WAIT, MEM_WAIT, MEM_WAIT, RUN; pipeHold=1 for exactly 3 cycles; stallCycles=3.
- Timeout: MAX_WAIT=4, memReady held at 0 → halted=1 after the 5th frozen cycle; a later memReady=1 is ignored; rst returns state=00.
- Reset mid-wait: rst asserted asynchronously in the 2nd MEM_WAIT cycle → state=RUN and waitCnt=0 immediately; the next memStall restarts the count at 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   Datapath -> controller : ifidRs, ifidRt, ifidUsesRt, idexMemRead, idexRt,
//                            exPcSrc, memReq, memReady
//   Controller -> datapath : pcWrite, ifidWrite, ifidFlush, idexBubble,
//                            pipeHold, halted, state
//   With HAZARD_PERF_EN    : stallCycles, flushCount (PERF_W bits each)
// Modports: master = datapath side, slave = controller side.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int unsigned PERF_W = 16
);
    logic [4:0] ifidRs;
    logic [4:0] ifidRt;
    logic       ifidUsesRt;
    logic       idexMemRead;
    logic [4:0] idexRt;
    logic [1:0] exPcSrc;
    logic       memReq;
    logic       memReady;

    logic       pcWrite;
    logic       ifidWrite;
    logic       ifidFlush;
    logic       idexBubble;
    logic       pipeHold;
    logic       halted;
    logic [1:0] state;
`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stallCycles;
    logic [PERF_W-1:0] flushCount;
`endif

    modport master (
        output ifidRs, ifidRt, ifidUsesRt, idexMemRead, idexRt, exPcSrc,
               memReq, memReady,
`ifdef HAZARD_PERF_EN
        input  stallCycles, flushCount,
`endif
        input  pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold, halted, state
    );

    modport slave (
        input  ifidRs, ifidRt, ifidUsesRt, idexMemRead, idexRt, exPcSrc,
               memReq, memReady,
`ifdef HAZARD_PERF_EN
        output stallCycles, flushCount,
`endif
        output pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold, halted, state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard/sequencing controller for the 5-stage MIPS pipeline. Produces the
// PC, IF/ID and ID/EX controls for load-use stalls, EX-resolved redirects and
// multi-cycle data-memory waits, with a watchdog that halts the pipeline if
// memory never answers.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   hz   - pipe_hazard_ctrl_if.slave (hazard inputs, pipeline controls,
//          debug state, optional perf counters)
// Outputs are Mealy: decoded from the registered state and current inputs.
// Optional feature macro: HAZARD_PERF_EN adds saturating stallCycles and
// flushCount counters.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned PERF_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic load_use_s;
    logic mem_stall_s;
    logic redirect_s;
    logic pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s, pipe_hold_s, halted_s;

    // Hazard detection terms.
    always_comb begin
        load_use_s  = hz.idexMemRead && (hz.idexRt != 5'd0) &&
                      ((hz.idexRt == hz.ifidRs) || (hz.ifidUsesRt && (hz.idexRt == hz.ifidRt)));
        mem_stall_s = hz.memReq && !hz.memReady;
        redirect_s  = (hz.exPcSrc != 2'b00);
    end

    // Next-state and control decode; defaults are normal advance.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        pipe_hold_s   = 1'b0;
        halted_s      = 1'b0;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if ((state_q == ST_RUN && mem_stall_s) ||
                    (state_q == ST_MEM_WAIT && !hz.memReady)) begin
                    // Full freeze while the data memory is busy.
                    pc_write_s   = 1'b0;
                    ifid_write_s = 1'b0;
                    pipe_hold_s  = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = 8'd1;
                    end else if (wait_cnt_q < MAX_WAIT_C) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end else begin
                        state_d = ST_HALT;
                    end
                end else begin
                    // Release (or plain RUN): EX inputs were held through
                    // the freeze, so redirect/load-use are resolved now.
                    state_d = ST_RUN;
                    if (state_q == ST_MEM_WAIT) begin
                        wait_cnt_d = 8'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                    if (redirect_s) begin
                        // Redirect outranks load-use: the load-use victim
                        // is on the wrong path and gets squashed anyway.
                        ifid_flush_s  = 1'b1;
                        idex_bubble_s = 1'b1;
                    end else if (load_use_s) begin
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        idex_bubble_s = 1'b1;
                    end else begin
                        idex_bubble_s = 1'b0;
                    end
                end
            end
            ST_HALT: begin
                pc_write_s   = 1'b0;
                ifid_write_s = 1'b0;
                pipe_hold_s  = 1'b1;
                halted_s     = 1'b1;
            end
            default: begin
                // Unreachable encoding: recover to RUN with a frozen cycle.
                pc_write_s   = 1'b0;
                ifid_write_s = 1'b0;
                pipe_hold_s  = 1'b1;
                state_d      = ST_RUN;
                wait_cnt_d   = 8'd0;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Drive the interface outputs.
    always_comb begin
        hz.pcWrite    = pc_write_s;
        hz.ifidWrite  = ifid_write_s;
        hz.ifidFlush  = ifid_flush_s;
        hz.idexBubble = idex_bubble_s;
        hz.pipeHold   = pipe_hold_s;
        hz.halted     = halted_s;
        hz.state      = state_q;
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;
    logic              count_en_s;

    // Counting is suspended once the pipeline is halted.
    always_comb begin
        count_en_s = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= {PERF_W{1'b0}};
            flush_cnt_q <= {PERF_W{1'b0}};
        end else begin
            if (count_en_s && !pc_write_s && (stall_cnt_q != {PERF_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (count_en_s && ifid_flush_s && (flush_cnt_q != {PERF_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
        end
    end

    // Counter outputs.
    always_comb begin
        hz.stallCycles = stall_cnt_q;
        hz.flushCount  = flush_cnt_q;
    end
`endif
endmodule
